// File: rtl/mux_n_pipe.sv
// mux_n_pipe
//   NUM_IN:1 signed word selector with a registered valid/ready output stage.
//   An output register plus a skid register give full throughput under
//   backpressure, and in_ready comes straight from state flops.
//
//   Build option: MUX_ROUND_ROBIN_EN
//     defined   - the select port is ignored; an internal pointer picks the
//                 channel and advances on every accept; err_sel is tied to 0
//     undefined - the channel comes from select; an out-of-range select on
//                 accept sets the sticky err_sel flag
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   Din        in   NUM_IN x DATA_WIDTH words, Din[i] is channel i
//   select     in   channel index, sampled on accept
//   in_valid   in   upstream offers Din/select
//   in_ready   out  block can accept this cycle (registered)
//   Dout       out  selected word (registered)
//   out_sel    out  channel index that produced Dout
//   out_valid  out  Dout/out_sel valid
//   out_ready  in   downstream accepts this cycle
//   err_sel    out  sticky: an out-of-range select was accepted
//
// state   | meaning
// S_EMPTY | output reg and skid reg both empty
// S_ONE   | output reg holds a word, skid reg empty
// S_FULL  | output reg and skid reg both hold a word, in_ready low

module mux_n_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 9,
  localparam int SEL_WIDTH = $clog2(NUM_IN)
) (
  input  logic                                Clk,
  input  logic                                Reset_n,
  input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]   Din,
  input  logic [SEL_WIDTH-1:0]                select,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic signed [DATA_WIDTH-1:0]        Dout,
  output logic [SEL_WIDTH-1:0]                out_sel,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                err_sel
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_WIDTH-1:0]    out_sel_q, out_sel_d;
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [SEL_WIDTH-1:0]    skid_sel_q, skid_sel_d;

  logic                    accept, drain;
  logic [SEL_WIDTH-1:0]    sel_eff;
  logic [DATA_WIDTH-1:0]   mux_word;

  assign out_valid = (state_q != S_EMPTY);
  assign in_ready  = (state_q != S_FULL);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign Dout      = out_data_q;
  assign out_sel   = out_sel_q;

`ifdef MUX_ROUND_ROBIN_EN
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  assign sel_eff = rr_ptr_q;
  assign err_sel = 1'b0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (rr_ptr_q == SEL_WIDTH'(NUM_IN - 1)) rr_ptr_d = '0;
      else                                    rr_ptr_d = rr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`else
  localparam logic [SEL_WIDTH:0] NUM_IN_L = (SEL_WIDTH + 1)'(NUM_IN);

  logic err_q, err_d;
  logic sel_oor;

  assign sel_eff = select;
  assign sel_oor = ({1'b0, select} >= NUM_IN_L);
  assign err_sel = err_q;
  assign err_d   = err_q | (accept & sel_oor);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
`endif

  // No channel matches an out-of-range index, so such a word becomes 0.
  always_comb begin
    mux_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel_eff == SEL_WIDTH'(i)) mux_word = Din[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d    = S_ONE;
          out_data_d = mux_word;
          out_sel_d  = sel_eff;
        end
      end
      S_ONE: begin
        if (accept && drain) begin
          out_data_d = mux_word;
          out_sel_d  = sel_eff;
        end else if (accept) begin
          state_d     = S_FULL;
          skid_data_d = mux_word;
          skid_sel_d  = sel_eff;
        end else if (drain) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (drain) begin
          state_d    = S_ONE;
          out_data_d = skid_data_q;
          out_sel_d  = skid_sel_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_EMPTY;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
module tb_mux_n_pipe;

  localparam int DW = 32;
  localparam int NI = 9;
  localparam int SW = $clog2(NI);

  logic                  Clk = 1'b0;
  logic                  Reset_n;
  logic [NI-1:0][DW-1:0] Din;
  logic [SW-1:0]         select;
  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         Dout;
  logic [SW-1:0]         out_sel;
  logic                  out_valid;
  logic                  out_ready;
  logic                  err_sel;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } entry_t;

  entry_t mq[$];
  logic   m_err;
  int     m_ptr;

  mux_n_pipe #(.DATA_WIDTH(DW), .NUM_IN(NI)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Din(Din), .select(select),
    .in_valid(in_valid), .in_ready(in_ready), .Dout(Dout),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .err_sel(err_sel)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("err_sel", 64'(err_sel), 64'(m_err));
    if (mq.size() > 0) begin
      chk("dout", 64'(Dout), 64'(mq[0].d));
      chk("out_sel", 64'(out_sel), 64'(mq[0].s));
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_err = 1'b0;
    m_ptr = 0;
  endtask

  // Inputs are applied just after a falling edge; the model advances on the
  // rising edge and the DUT is compared on the following falling edge.
  task automatic step(input logic v, input logic [SW-1:0] s, input logic r);
    logic acc, dr;
    int   ch;
    entry_t e;
    in_valid  = v;
    select    = s;
    out_ready = r;
    acc = v && (mq.size() < 2);
    dr  = (mq.size() > 0) && r;
`ifdef MUX_ROUND_ROBIN_EN
    ch = m_ptr;
`else
    ch = int'(s);
`endif
    e.s = SW'(ch);
    e.d = (ch < NI) ? Din[ch] : '0;
    @(posedge Clk);
    if (dr) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(e);
      if (ch >= NI) m_err = 1'b1;
      m_ptr = (m_ptr + 1) % NI;
    end
    @(negedge Clk);
    compare_model();
  endtask

  task automatic base_din();
    for (int i = 0; i < NI; i++) Din[i] = 32'h0100_0000 + DW'(i);
  endtask

  initial begin
    Reset_n   = 1'b0;
    in_valid  = 1'b0;
    select    = '0;
    out_ready = 1'b0;
    base_din();
    model_clear();

    // in_valid during reset must be ignored
    @(negedge Clk);
    in_valid = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_dout", 64'(Dout), 64'h0);
    chk("rst_out_sel", 64'(out_sel), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_err_sel", 64'(err_sel), 64'h0);
    @(negedge Clk);
    in_valid = 1'b0;
    Reset_n  = 1'b1;

`ifndef MUX_ROUND_ROBIN_EN
    // first accepted word appears after one edge, then one per cycle
    step(1'b1, 4'd3, 1'b1);
    chk("t1_dout", 64'(Dout), 64'h0100_0003);
    chk("t1_sel", 64'(out_sel), 64'h3);
    chk("t1_model", 64'(mq[0].d), 64'h0100_0003);
    step(1'b1, 4'd3, 1'b1);
    chk("t1_valid2", 64'(out_valid), 64'h1);

    // sign preserved
    Din[8] = 32'hFFFF_FF85;
    step(1'b1, 4'd8, 1'b1);
    chk("t2_dout", 64'(Dout), 64'hFFFF_FF85);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    chk("t2_drained", 64'(out_valid), 64'h0);

    // backpressure fills output reg then skid
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 1'b0);
    chk("t3_in_ready", 64'(in_ready), 64'h0);
    chk("t3_dout", 64'(Dout), 64'h0100_0001);
    step(1'b1, 4'd5, 1'b0);
    chk("t3_hold", 64'(Dout), 64'h0100_0001);
    step(1'b0, 4'd0, 1'b1);
    chk("t3_dout2", 64'(Dout), 64'h0100_0002);
    chk("t3_in_ready2", 64'(in_ready), 64'h1);
    step(1'b0, 4'd0, 1'b1);

    // out-of-range select
    step(1'b1, 4'd12, 1'b1);
    chk("t4_dout", 64'(Dout), 64'h0);
    chk("t4_sel", 64'(out_sel), 64'hC);
    chk("t4_err", 64'(err_sel), 64'h1);
    step(1'b1, 4'd4, 1'b1);
    chk("t4_err_sticky", 64'(err_sel), 64'h1);
    step(1'b0, 4'd0, 1'b1);
`else
    // round-robin: select held at 0
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 4'd0, 1'b1);
      chk("rr_sel", 64'(out_sel), 64'(i % NI));
      chk("rr_err", 64'(err_sel), 64'h0);
    end
    step(1'b0, 4'd0, 1'b1);
`endif

    // reset while full discards everything, out_valid drops at once
    step(1'b1, 4'd6, 1'b0);
    step(1'b1, 4'd7, 1'b0);
    chk("t5_full", 64'(in_ready), 64'h0);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("t5_valid_async", 64'(out_valid), 64'h0);
    chk("t5_ready_async", 64'(in_ready), 64'h1);
    chk("t5_err_async", 64'(err_sel), 64'h0);
    model_clear();
    in_valid = 1'b1;
    @(posedge Clk);
    #1;
    chk("t5_ignore_in", 64'(out_valid), 64'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    in_valid = 1'b0;
    Din[5] = 32'h8000_1234;
    step(1'b1, 4'd5, 1'b0);
`ifndef MUX_ROUND_ROBIN_EN
    chk("t5_first", 64'(Dout), 64'h8000_1234);
`else
    chk("t5_first", 64'(out_sel), 64'h0);
`endif

    // randomized traffic against the queue model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NI; i++) Din[i] = $urandom();
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 9) == 0) ? SW'($urandom_range(NI, 15)) : SW'($urandom_range(0, NI - 1)),
           $urandom_range(0, 2) != 0);
    end
    for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1);
    chk("end_empty", 64'(out_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
